// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared screen sizes, control codes and console states
package vga_text_pkg;
   localparam int DEF_COLS = 80;
   localparam int DEF_ROWS = 30;
   localparam int VRAM_DEPTH = DEF_COLS * DEF_ROWS;
   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_FF = 8'h0C;
   localparam logic [7:0] CH_CR = 8'h0D;
   typedef enum logic [2:0] {IDLE, WRITE, SCROLL_RD, SCROLL_WR, SCROLL_FILL, CLEAR} console_state_t;
endpackage

// File: rtl/vga_text_console_cursor.sv
// text_cursor: cursor column/row with advance, newline, carriage-return, back and home moves
module text_cursor #(
   parameter int COLS = 80,
   parameter int ROWS = 30
) (
   input  logic       fpga_clk,
   input  logic       rst,
   input  logic       advance,
   input  logic       newline,
   input  logic       cr,
   input  logic       back,
   input  logic       home,
   output logic [6:0] col,
   output logic [4:0] row,
   output logic       wrap_row
);
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
   logic eol;
   assign eol = col == LAST_COL;
   assign wrap_row = row == LAST_ROW && (newline || (advance && eol));
   // Apply at most one move per cycle; the row holds at the last row so the screen scrolls instead
   always_ff @(posedge fpga_clk or posedge rst)
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (home) begin
         col <= '0;
         row <= '0;
      end else if (newline || (advance && eol)) begin
         col <= '0;
         row <= row == LAST_ROW ? row : row + 5'd1;
      end else if (advance)
         col <= col + 7'd1;
      else if (cr)
         col <= '0;
      else if (back && col != 7'd0)
         col <= col - 7'd1;
      else if (back && row != 5'd0) begin
         col <= LAST_COL;
         row <= row - 5'd1;
      end
endmodule

// File: rtl/vga_text_console.sv
// vga_text_console: byte stream to text VRAM writer with cursor, control codes, scroll and clear
module vga_text_console
   import vga_text_pkg::*;
#(
   parameter int COLS = DEF_COLS,
   parameter int ROWS = DEF_ROWS,
   parameter logic [7:0] BLANK_CHAR = 8'h20
) (
   input  logic        fpga_clk,
   input  logic        rst,
   input  logic [7:0]  char_in,
   input  logic        char_valid,
   output logic        char_ready,
   output logic [11:0] vram_addr,
   output logic [7:0]  vram_wdata,
   output logic        vram_we,
   input  logic [7:0]  vram_rdata,
   output logic [6:0]  cursor_col,
   output logic [4:0]  cursor_row,
   output logic        busy
);
   localparam logic [11:0] LINE = 12'(COLS);
   localparam logic [11:0] FILL_BASE = 12'((ROWS - 1) * COLS);
   localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
   console_state_t state;
   logic [7:0] wdata_q;
   logic [11:0] cur_addr;
   logic scroll_pend, accept, is_bs, is_lf, is_cr, is_ff, printable, wrap_row, at_origin;
   assign char_ready = state == IDLE && !rst;
   assign accept = char_valid && char_ready;
   assign is_bs = char_in == CH_BS;
   assign is_lf = char_in == CH_LF;
   assign is_cr = char_in == CH_CR;
   assign is_ff = char_in == CH_FF;
   assign printable = !(is_bs || is_lf || is_cr || is_ff);
   assign at_origin = cursor_col == 7'd0 && cursor_row == 5'd0;
   assign cur_addr = 12'(cursor_row) * LINE + 12'(cursor_col);
   assign vram_wdata = state == SCROLL_WR ? vram_rdata : wdata_q;
   text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
      .fpga_clk (fpga_clk),
      .rst      (rst),
      .advance  (accept && printable),
      .newline  (accept && is_lf),
      .cr       (accept && is_cr),
      .back     (accept && is_bs),
      .home     (state == CLEAR && vram_addr == LAST_CELL),
      .col      (cursor_col),
      .row      (cursor_row),
      .wrap_row (wrap_row)
   );
   // Console FSM; vram_addr doubles as the scroll source/destination and clear/fill index
   always_ff @(posedge fpga_clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         vram_addr <= '0;
         wdata_q <= '0;
         vram_we <= 1'b0;
         busy <= 1'b0;
         scroll_pend <= 1'b0;
      end else
         case (state)
            IDLE:
               if (accept) begin
                  if (is_ff) begin
                     state <= CLEAR;
                     vram_addr <= '0;
                     wdata_q <= BLANK_CHAR;
                     vram_we <= 1'b1;
                     busy <= 1'b1;
                  end else if (is_lf && wrap_row) begin
                     state <= SCROLL_RD;
                     vram_addr <= LINE;
                     busy <= 1'b1;
                  end else if (printable) begin
                     state <= WRITE;
                     vram_addr <= cur_addr;
                     wdata_q <= char_in;
                     vram_we <= 1'b1;
                     scroll_pend <= wrap_row;
                  end else if (is_bs && !at_origin) begin
                     state <= WRITE;
                     vram_addr <= cur_addr - 12'd1;
                     wdata_q <= BLANK_CHAR;
                     vram_we <= 1'b1;
                     scroll_pend <= 1'b0;
                  end
               end
            WRITE: begin
               vram_we <= 1'b0;
               state <= scroll_pend ? SCROLL_RD : IDLE;
               busy <= scroll_pend;
               if (scroll_pend) vram_addr <= LINE;
            end
            SCROLL_RD: begin
               state <= SCROLL_WR;
               vram_addr <= vram_addr - LINE;
               vram_we <= 1'b1;
            end
            SCROLL_WR:
               if (vram_addr == FILL_BASE - 12'd1) begin
                  state <= SCROLL_FILL;
                  vram_addr <= FILL_BASE;
                  wdata_q <= BLANK_CHAR;
               end else begin
                  state <= SCROLL_RD;
                  vram_addr <= vram_addr + LINE + 12'd1;
                  vram_we <= 1'b0;
               end
            SCROLL_FILL, CLEAR:
               if (vram_addr == LAST_CELL) begin
                  state <= IDLE;
                  vram_we <= 1'b0;
                  busy <= 1'b0;
               end else
                  vram_addr <= vram_addr + 12'd1;
            default: state <= IDLE;
         endcase
endmodule
